// File: rtl/pc_fetch_sequencer.sv
// PC and instruction-fetch sequencer for the MIPS core: picks the next PC,
// runs the imem request/ready handshake and holds the fetched word for decode.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180,
  parameter int          MAX_WAIT     = 15
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  input  logic        id_ready,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        exc,
  output logic [31:0] pc,
  output logic [31:0] epc,
  output logic        fetch_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

  state_t      state, state_nx;
  logic [31:0] pc_nx, epc_nx, instr_nx;
  logic        vld_nx, err_nx;
  logic [7:0]  cnt, cnt_nx, cnt_inc;

  // Target low bits are forced to word alignment and never read.
  logic unused_tgt;
  assign unused_tgt = ^{branch_target[1:0], jump_target[1:0]};

  assign imem_req  = (state == REQ) || (state == WAIT);
  assign imem_addr = pc;
  assign cnt_inc   = cnt + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_VECTOR;
      epc         <= '0;
      instr_out   <= '0;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
      cnt         <= '0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      epc         <= epc_nx;
      instr_out   <= instr_nx;
      instr_valid <= vld_nx;
      fetch_err   <= err_nx;
      cnt         <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    epc_nx   = epc;
    instr_nx = instr_out;
    vld_nx   = instr_valid;
    err_nx   = 1'b0;
    cnt_nx   = cnt;
    if (state == IDLE) begin
      state_nx = REQ;
    end else if (exc) begin
      epc_nx   = pc;
      pc_nx    = EXC_VECTOR;
      vld_nx   = 1'b0;
      state_nx = REQ;
    end else if (!stall && branch_taken) begin
      pc_nx    = {branch_target[31:2], 2'b00};
      vld_nx   = 1'b0;
      state_nx = REQ;
    end else if (!stall && jump) begin
      pc_nx    = {jump_target[31:2], 2'b00};
      vld_nx   = 1'b0;
      state_nx = REQ;
    end else begin
      case (state)
        REQ: begin
          cnt_nx   = '0;
          state_nx = WAIT;
          if (imem_ready) begin
            instr_nx = imem_rdata;
            vld_nx   = 1'b1;
            state_nx = HOLD;
          end
        end
        WAIT: begin
          if (imem_ready) begin
            instr_nx = imem_rdata;
            vld_nx   = 1'b1;
            state_nx = HOLD;
          end else if (cnt_inc == MAX_W) begin
            // MAX_WAIT consecutive empty WAIT cycles: abandon and trap.
            err_nx   = 1'b1;
            epc_nx   = pc;
            pc_nx    = EXC_VECTOR;
            state_nx = REQ;
          end else begin
            cnt_nx = cnt_inc;
          end
        end
        HOLD: begin
          if (id_ready && !stall) begin
            pc_nx    = pc + 32'd4;
            vld_nx   = 1'b0;
            state_nx = REQ;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
Controls the program counter and instruction fetch for the MIPS core. Each cycle it chooses the next PC from these sources: reset vector, sequential PC+4, branch target, jump target, or exception vector. It runs the request/ready handshake with instruction memory and holds the fetched instruction until decode accepts it. It sits between the next-PC mux logic, the PC register path and imem.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
EXC_VECTOR, 32'h0000_0180, PC loaded on exception or fetch timeout
MAX_WAIT, 15, cycles in WAIT without imem_ready before a fetch error (1..255)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
imem_req  out  1  fetch request, valid in REQ/WAIT
imem_addr  out  32  fetch address, equal to pc
imem_ready  in  1  imem data valid this cycle
imem_rdata  in  32  instruction word from imem
instr_out  out  32  captured instruction to decode
instr_valid  out  1  instr_out valid
id_ready  in  1  decode accepts instr_out this cycle
stall  in  1  pipeline stall from hazard unit
branch_taken  in  1  redirect to branch_target
branch_target  in  32  branch destination
jump  in  1  redirect to jump_target
jump_target  in  32  jump destination, {pc[31:28],idx,2'b00} pre-formed
exc  in  1  exception request
pc  out  32  current PC
epc  out  32  PC saved on exception or timeout
fetch_err  out  1  one-cycle pulse on fetch timeout

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE; pc=RESET_VECTOR; epc=0; instr_out=0.
  - instr_valid=0; imem_req=0; fetch_err=0; wait counter=0.
- Registered outputs: all outputs registered except imem_req and imem_addr, which decode combinationally from state and pc.
- States and transitions:
  - IDLE: one cycle after reset release, then REQ.
  - REQ: imem_req=1. Clear the wait counter. Next state is WAIT. If imem_ready=1 in this cycle, capture as in WAIT.
  - WAIT: imem_req=1.
    - imem_ready=1: instr_out<=imem_rdata, instr_valid<=1, go to HOLD.
    - Otherwise increment the counter. When counter==MAX_WAIT: fetch_err<=1 for one cycle, epc<=pc, pc<=EXC_VECTOR, go to REQ.
  - HOLD: imem_req=0; instr_valid=1.
    - If id_ready=1 and stall=0: pc<=pc+4, instr_valid<=0, go to REQ.
    - The +4 add is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- Redirect priority, evaluated each cycle in REQ, WAIT and HOLD: exc > branch_taken > jump > sequential/handshake.
  - exc: epc<=pc, pc<=EXC_VECTOR, instr_valid<=0, go to REQ. exc is honoured even when stall=1.
  - branch_taken (stall=0): pc<={branch_target[31:2],2'b00}, instr_valid<=0, go to REQ.
  - jump (stall=0, no branch): pc<={jump_target[31:2],2'b00}, instr_valid<=0, go to REQ.
  - stall=1: branch_taken and jump are ignored. They must be re-asserted by the pipeline.
- Simultaneous events:
  - Any redirect in the same cycle as imem_ready discards that response; instr_out is not updated.
  - A redirect and a timeout in the same cycle: the redirect wins, fetch_err=0.
  - Redirect/exc inputs in IDLE are ignored.
- Latency:
  - Reset release to first imem_req: 1 cycle.
  - Zero-wait fetch (ready in REQ): instr_valid asserted 1 cycle after the request.
  - Redirect to new imem_addr: 1 cycle.
- Reset mid-fetch: immediate return to the reset values; any in-flight response is dropped.

Test Plan:
- Reset then imem_ready tied 1, id_ready=1: imem_addr sequence 0x0, 0x4, 0x8. instr_valid pulses once per fetch; instr_out matches imem_rdata.
- imem_ready delayed 3 cycles: imem_req stays 1 for 4 cycles. instr_out captured once; pc unchanged until id_ready.
- imem_ready never asserted, MAX_WAIT=15: fetch_err single pulse 16 cycles after REQ. epc=old pc; next imem_addr=0x180.
- In HOLD with branch_taken=1, branch_target=0x1003, and jump=1 in the same cycle: pc=0x1000. instr_valid drops; the next fetch address is 0x1000.
- stall=1 with branch_taken=1, then exc=1 in the next cycle: the branch is ignored, then epc=current pc and pc=0x180.
- pc forced to 0xFFFF_FFFC, accept: next imem_addr=0x0. rst asserted in WAIT: outputs at reset values immediately, without waiting for a clock edge.
